ramr_stream: RTL and testbench

Sequential burst reader for the 128 x 32 `ramw` buffer. It drives the buffer's read-only port B (address out, 32-bit data in, no output register) and replays a programmed window of words as a valid/ready stream. It is the read-side counterpart to the port-A writer in tinycomp: the writer fills the buffer, then this block drains it to a downstream consumer. Internally it has a 2-entry skid FIFO, so backpressure never drops or repeats a word, and it sustains 1 word/cycle.

---
 rtl/ramr_stream_if.sv | 31 +++
 rtl/ramr_stream.sv | 169 ++++++++++++++++
 tb/tb_ramr_stream.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramr_stream_if.sv
// ramr_stream_if
// ---------------
// Valid/ready stream bundle carrying words out of the ramr_stream reader.
//
// Signals:
//   m_valid  producer -> consumer  word on m_data is valid
//   m_data   producer -> consumer  stream word, WIDTH bits
//   m_ready  consumer -> producer  consumer accepts; transfer on m_valid && m_ready
//
// Modports:
//   master  the producer side (ramr_stream)
//   slave   the consumer side
interface ramr_stream_if #(
    parameter int WIDTH = 32
);
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/ramr_stream.sv
// ramr_stream
// -----------
// Sequential burst reader for the ramw buffer's read-only port B. A command
// (base, len) selects a window of len+1 words, read with the address wrapping
// modulo 2^DEPTH_LOG2, and the words are replayed in order on a valid/ready
// stream. A 2-entry skid FIFO plus a one-read-in-flight credit rule lets the
// block sustain one word per cycle while never dropping or repeating a word
// under backpressure.
//
// Ports:
//   clk       single clock, also the clock of the RAM read port
//   rst_n     synchronous active-low reset
//   start     command strobe, only looked at while busy = 0
//   base      first word address, captured with start
//   len       burst length minus one, captured with start
//   busy      a command is in progress (READ, DRAIN or DONE)
//   done      one-cycle pulse the cycle after the last word is accepted
//   ram_addr  read address to the RAM; holds its last value when idle
//   ram_dout  RAM read data, valid the cycle after ram_addr is presented
//   m         stream output (m_valid, m_data, m_ready)
module ramr_stream #(
    parameter int DEPTH_LOG2 = 7,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] base,
    input  logic [DEPTH_LOG2-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    input  logic [WIDTH-1:0]      ram_dout,
    ramr_stream_if.master         m
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Read pointer, words still to issue (minus one), and the last address
    // put on the RAM so ram_addr can hold when no read is issued.
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2-1:0] remaining;
    logic [DEPTH_LOG2-1:0] last_addr;

    // One read may be in flight: issued last cycle, data arriving this cycle.
    logic inflight;

    // Two-entry FIFO with separate write/read indices.
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       occ;

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] credit;

    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = fifo_mem[rd_idx];

    assign pop  = m.m_valid && m.m_ready;
    assign push = inflight;

    // Words already committed to the FIFO: stored plus in flight. A word
    // popped this cycle frees a slot, so a new read may be issued as long as
    // the committed count minus the pop stays below the FIFO depth.
    assign credit = {1'b0, occ} + {2'b00, inflight};
    assign issue  = (state == READ) && (credit < (3'd2 + {2'b00, pop}));

    assign ram_addr = issue ? ptr : last_addr;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN looks one cycle ahead: it leaves as soon as the
    // last stored word is being popped with nothing in flight, so done lands
    // in the cycle right after the final transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (issue && (remaining == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, address generation and read tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                ptr       <= base;
                remaining <= len;
            end else if (issue) begin
                ptr       <= ptr + DEPTH_LOG2'(1);
                remaining <= remaining - DEPTH_LOG2'(1);
            end
            if (issue) begin
                last_addr <= ptr;
            end
            inflight <= issue;
        end
    end

    // Skid FIFO. Captured RAM data goes to the tail; the head drives m_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= ram_dout;
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_ramr_stream.sv
// tb_ramr_stream
// --------------
// Self-checking bench for ramr_stream. Holds a behavioural model of the
// ramw port B (registered read, one-cycle latency), issues commands and
// keeps a queue of expected stream words, popping one per accepted transfer.
module tb_ramr_stream;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  base;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic [6:0]  ram_addr;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:127];
    logic [31:0] exp_q [$];

    int checks;
    int failures;

    ramr_stream_if #(.WIDTH(32)) sif ();

    ramr_stream #(
        .DEPTH_LOG2(7),
        .WIDTH     (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .ram_addr(ram_addr),
        .ram_dout(ram_dout),
        .m       (sif)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM port B model: registered read, no output register beyond that.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue a command at the current negedge (cycle 0); returns at the
    // negedge of cycle 1 with start released.
    task automatic send_cmd(input logic [6:0] b, input logic [6:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        for (int i = 0; i <= int'(l); i++) begin
            exp_q.push_back(mem[7'(int'(b) + i)]);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream words out with the given m_ready probability until done,
    // checking data order, stall stability, FIFO occupancy and (when strict)
    // that no bubble appears once the stream has started.
    task automatic drain(input int pct, input bit strict, input int budget);
        bit          seen_done;
        bit          saw_first;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [31:0] exp;
        seen_done  = 1'b0;
        saw_first  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < budget && !seen_done; c++) begin
            @(negedge clk);
            sif.m_ready = ($urandom_range(0, 99) < pct);
            if (prev_stall) begin
                checks++;
                if (sif.m_valid !== 1'b1 || sif.m_data !== prev_data) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                             sif.m_valid, sif.m_data, prev_data);
                end
            end
            if (strict && saw_first && exp_q.size() != 0) begin
                checks++;
                if (sif.m_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL no_bubble: got valid=%b expected valid=1", sif.m_valid);
                end
            end
            checks++;
            if (dut.occ > 2'd2) begin
                failures++;
                $display("[TB] FAIL occupancy: got %0d expected <=2", dut.occ);
            end
            if (sif.m_valid === 1'b1) begin
                saw_first = 1'b1;
            end
            if (sif.m_valid === 1'b1 && sif.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL extra_word: got %h expected none", sif.m_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (sif.m_data !== exp) begin
                        failures++;
                        $display("[TB] FAIL stream_data: got %h expected %h", sif.m_data, exp);
                    end
                end
            end
            prev_stall = (sif.m_valid === 1'b1) && !sif.m_ready;
            prev_data  = sif.m_data;
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL words_missing: got %0d left expected 0", exp_q.size());
        end
    endtask

    // Reset state of all outputs.
    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        base        = '0;
        len         = '0;
        sif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (sif.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", sif.m_valid); end
        if (sif.m_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", sif.m_data); end
        if (ram_addr !== 7'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", ram_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Cycle-exact timing of a 4-word burst with m_ready held high.
    task automatic test_basic_timing();
        logic [31:0] exp;
        sif.m_ready = 1'b1;
        send_cmd(7'd5, 7'd3);
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL c1_busy: got %b expected 1", busy); end
        if (ram_addr !== 7'd5) begin failures++; $display("[TB] FAIL c1_addr: got %0d expected 5", ram_addr); end
        @(negedge clk);
        checks++;
        if (sif.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL c2_valid: got %b expected 0", sif.m_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks += 3;
            if (sif.m_valid !== 1'b1) begin failures++; $display("[TB] FAIL word%0d_valid: got %b expected 1", k, sif.m_valid); end
            if (sif.m_data !== exp) begin failures++; $display("[TB] FAIL word%0d_data: got %h expected %h", k, sif.m_data, exp); end
            if (done !== 1'b0) begin failures++; $display("[TB] FAIL word%0d_done: got %b expected 0", k, done); end
        end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL c7_done: got %b expected 1", done); end
        if (sif.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL c7_valid: got %b expected 0", sif.m_valid); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL c8_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL c8_done: got %b expected 0", done); end
    endtask

    // Address wrap from 126 through 0.
    task automatic test_wrap();
        sif.m_ready = 1'b1;
        send_cmd(7'd126, 7'd3);
        drain(100, 1'b1, 100);
        @(negedge clk);
    endtask

    // Full 128-word burst under random backpressure.
    task automatic test_long_random();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        sif.m_ready = 1'b0;
        send_cmd(7'd0, 7'd127);
        drain(50, 1'b0, 3000);
        @(negedge clk);
    endtask

    // m_ready low from the start: two reads issued, then the stream stalls.
    task automatic test_backpressure();
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
        sif.m_ready = 1'b0;
        send_cmd(7'd20, 7'd7);
        @(negedge clk);
        checks++;
        if (ram_addr !== 7'd21) begin failures++; $display("[TB] FAIL bp_c2_addr: got %0d expected 21", ram_addr); end
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            checks += 3;
            if (sif.m_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_c%0d_valid: got %b expected 1", c, sif.m_valid); end
            if (sif.m_data !== exp_q[0]) begin failures++; $display("[TB] FAIL bp_c%0d_data: got %h expected %h", c, sif.m_data, exp_q[0]); end
            if (ram_addr !== 7'd21) begin failures++; $display("[TB] FAIL bp_c%0d_addr: got %0d expected 21", c, ram_addr); end
        end
        drain(100, 1'b1, 100);
        @(negedge clk);
    endtask

    // start while busy and in the DONE cycle must be ignored.
    task automatic test_start_ignored();
        for (int i = 0; i < 128; i++) mem[i] = 32'h2000_0000 + i;
        sif.m_ready = 1'b1;
        send_cmd(7'd40, 7'd5);
        start = 1'b1;
        base  = 7'd0;
        len   = 7'd0;
        @(negedge clk);
        start = 1'b0;
        drain(100, 1'b1, 100);
        start = 1'b1;
        base  = 7'd99;
        len   = 7'd0;
        @(negedge clk);
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL ign_done: got %b expected 0", done); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_busy2: got %b expected 0", busy); end
        if (sif.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL ign_valid: got %b expected 0", sif.m_valid); end
    endtask

    // A new command accepted in the cycle right after done.
    task automatic test_back_to_back();
        sif.m_ready = 1'b1;
        send_cmd(7'd60, 7'd2);
        drain(100, 1'b1, 100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
        send_cmd(7'd70, 7'd2);
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
        if (ram_addr !== 7'd70) begin failures++; $display("[TB] FAIL b2b_addr: got %0d expected 70", ram_addr); end
        drain(100, 1'b1, 100);
        @(negedge clk);
    endtask

    // Reset after two of eight words, then a fresh burst.
    task automatic test_reset_mid();
        logic [31:0] exp;
        for (int i = 0; i < 128; i++) mem[i] = i;
        sif.m_ready = 1'b1;
        send_cmd(7'd10, 7'd7);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (sif.m_valid !== 1'b1 || sif.m_data !== exp) begin
                failures++;
                $display("[TB] FAIL rm_word%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, sif.m_valid, sif.m_data, exp);
            end
        end
        @(negedge clk);
        sif.m_ready = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        checks += 5;
        if (sif.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_valid: got %b expected 0", sif.m_valid); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rm_busy: got %b expected 0", busy); end
        if (ram_addr !== 7'd0) begin failures++; $display("[TB] FAIL rm_addr: got %0d expected 0", ram_addr); end
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL rm_done: got %b expected 0", done); end
        if (sif.m_data !== 32'h0) begin failures++; $display("[TB] FAIL rm_data: got %h expected 0", sif.m_data); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rm_quiet: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
        for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101);
        sif.m_ready = 1'b1;
        send_cmd(7'd10, 7'd7);
        drain(100, 1'b1, 100);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 128; i++) mem[i] = i;
        test_reset();
        test_basic_timing();
        test_wrap();
        test_long_random();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
